// File: rtl/sap1_prog_loader_pkg.sv
// Shared widths and FSM state encoding for the SAP-1 programming-mode loader.
package sap1_prog_loader_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_MAR = 3'd1,
        ST_SETUP    = 3'd2,
        ST_WRITE    = 3'd3,
        ST_HOLD     = 3'd4,
        ST_WAIT_REL = 3'd5
    } state_e;

endpackage

// File: rtl/sap1_prog_loader_if.sv
// Switch/button inputs and MAR/RAM write bus of the programming loader.
interface sap1_prog_loader_if
    import sap1_prog_loader_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    logic          prog;
    logic          btn_wr;
    logic [AW-1:0] sw_addr;
    logic [DW-1:0] sw_data;
    logic          auto_inc;
    logic [AW-1:0] addr_out;
    logic          nLm;
    logic [DW-1:0] ram_din;
    logic          nwe;
    logic          busy;
    logic          done;
    logic [AW-1:0] ptr;

    // master = loader side, drives the memory strobes
    modport master (
        input  prog, btn_wr, sw_addr, sw_data, auto_inc,
        output addr_out, nLm, ram_din, nwe, busy, done, ptr
    );

    modport slave (
        output prog, btn_wr, sw_addr, sw_data, auto_inc,
        input  addr_out, nLm, ram_din, nwe, busy, done, ptr
    );
endinterface

// File: rtl/sap1_prog_loader_debounce.sv
// Two-flop synchroniser plus stable-level debouncer for the raw write button.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);
    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // flip only on the DEBOUNCE_CYC-th consecutive mismatch
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;
endmodule

// File: rtl/sap1_prog_loader.sv
// Programming-mode front end: debounced button -> MAR load strobe -> RAM write strobe.
//  state    | meaning
//  IDLE     | waiting for a debounced press in programming mode
//  LOAD_MAR | nLm low, snapshot address presented to MAR
//  SETUP    | strobes idle, address/data settling
//  WRITE    | nwe low for WR_PULSE cycles
//  HOLD     | nwe released, data still driven, done pulse
//  WAIT_REL | waiting for the button to be released
module sap1_prog_loader
    import sap1_prog_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int WR_PULSE     = 2
) (
    input logic              CLK,
    input logic              CLR,
    sap1_prog_loader_if.master bus
);
    localparam int WR_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

    logic              btn_db;
    logic              start;
    logic              btn_db_prev_q, btn_db_prev_d;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              from_ptr_q, from_ptr_d;
    logic [WR_W-1:0]   wr_cnt_q, wr_cnt_d;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk     (CLK),
        .rst     (CLR),
        .btn_raw (bus.btn_wr),
        .btn_db  (btn_db)
    );

    assign start = btn_db & ~btn_db_prev_q;

    always_comb begin
        btn_db_prev_d = btn_db;
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        ptr_d         = ptr_q;
        from_ptr_d    = from_ptr_q;
        wr_cnt_d      = wr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !bus.prog) begin
                    addr_d     = bus.auto_inc ? ptr_q : bus.sw_addr;
                    data_d     = bus.sw_data;
                    from_ptr_d = bus.auto_inc;
                    state_d    = ST_LOAD_MAR;
                end
            end
            ST_LOAD_MAR: state_d = ST_SETUP;
            ST_SETUP: begin
                state_d  = ST_WRITE;
                wr_cnt_d = WR_W'(WR_PULSE - 1);
            end
            ST_WRITE: begin
                if (wr_cnt_q == '0) begin
                    state_d = ST_HOLD;
                    if (from_ptr_q) ptr_d = ptr_q + 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q - 1'b1;
                end
            end
            ST_HOLD:     state_d = ST_WAIT_REL;
            ST_WAIT_REL: if (!btn_db) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // leaving programming mode aborts the sequence without committing the pointer
        if (state_q != ST_IDLE && bus.prog) begin
            state_d = ST_IDLE;
            ptr_d   = ptr_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            btn_db_prev_q <= 1'b0;
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            ptr_q         <= '0;
            from_ptr_q    <= 1'b0;
            wr_cnt_q      <= '0;
        end else begin
            btn_db_prev_q <= btn_db_prev_d;
            state_q       <= state_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            ptr_q         <= ptr_d;
            from_ptr_q    <= from_ptr_d;
            wr_cnt_q      <= wr_cnt_d;
        end
    end

    assign bus.nLm      = (state_q != ST_LOAD_MAR);
    assign bus.nwe      = (state_q != ST_WRITE);
    assign bus.done     = (state_q == ST_HOLD);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.addr_out = addr_q;
    assign bus.ram_din  = data_q;
    assign bus.ptr      = ptr_q;
endmodule

// File: tb/tb_sap1_prog_loader.sv
// Directed bench for sap1_prog_loader with a MAR/RAM model on the write bus.
module tb_sap1_prog_loader;
    import sap1_prog_loader_pkg::*;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    sap1_prog_loader_if bus ();

    sap1_prog_loader dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int nlm_cnt  = 0;
    int nwe_cnt  = 0;
    int done_cnt = 0;
    int b_nlm, b_nwe, b_done;

    logic [7:0] mem [16];
    logic [3:0] mar;

    always @(posedge clk) begin
        if (bus.nLm === 1'b0) mar <= bus.addr_out;
        if (bus.nwe === 1'b0) mem[mar] <= bus.ram_din;
    end

    always @(negedge clk) begin
        if (bus.nLm === 1'b0) nlm_cnt++;
        if (bus.nwe === 1'b0) nwe_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 1);
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) seen = 1'b1;
        end
        chk(tag, 32'(seen), 1);
    endtask

    task automatic wait_low(input string tag, input bit use_nwe);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if ((use_nwe ? bus.nwe : bus.nLm) === 1'b0) seen = 1'b1;
        end
        chk(tag, 32'(seen), 1);
    endtask

    task automatic press(input string tag, input logic [3:0] a, input logic [7:0] d);
        bus.sw_addr = a;
        bus.sw_data = d;
        bus.btn_wr  = 1'b1;
        wait_done(tag);
        bus.btn_wr  = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        bit bad;
        clr          = 1'b1;
        bus.prog     = 1'b0;
        bus.btn_wr   = 1'b1;
        bus.auto_inc = 1'b0;
        bus.sw_addr  = 4'hA;
        bus.sw_data  = 8'h3C;

        // reset with the button already held
        @(negedge clk);
        chk("rst_nlm", 32'(bus.nLm), 1);
        chk("rst_nwe", 32'(bus.nwe), 1);
        chk("rst_addr", 32'(bus.addr_out), 0);
        chk("rst_din", 32'(bus.ram_din), 0);
        chk("rst_ptr", 32'(bus.ptr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        @(negedge clk);
        clr = 1'b0;

        // 2 sync + 16 debounce edges, then the FSM edge
        b_nlm = nlm_cnt; b_nwe = nwe_cnt; b_done = done_cnt;
        bad = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (bus.nLm !== 1'b1 || bus.busy !== 1'b0) bad = 1'b1;
        end
        chk("db_quiet", 32'(bad), 0);
        @(negedge clk);
        chk("t1_nlm", 32'(bus.nLm), 0);
        chk("t1_addr", 32'(bus.addr_out), 'hA);
        chk("t1_busy", 32'(bus.busy), 1);
        @(negedge clk);
        chk("setup_nlm", 32'(bus.nLm), 1);
        chk("setup_nwe", 32'(bus.nwe), 1);
        @(negedge clk);
        chk("wr1_nwe", 32'(bus.nwe), 0);
        chk("wr1_din", 32'(bus.ram_din), 'h3C);
        @(negedge clk);
        chk("wr2_nwe", 32'(bus.nwe), 0);
        @(negedge clk);
        chk("hold_done", 32'(bus.done), 1);
        chk("hold_nwe", 32'(bus.nwe), 1);
        @(negedge clk);
        chk("wrel_done", 32'(bus.done), 0);
        chk("wrel_busy", 32'(bus.busy), 1);
        chk("mem_A", 32'(mem[4'hA]), 'h3C);
        chk("clean_nlm_cnt", 32'(nlm_cnt - b_nlm), 1);
        chk("clean_nwe_cnt", 32'(nwe_cnt - b_nwe), 2);
        bus.btn_wr = 1'b0;
        wait_idle("clean_idle");
        chk("clean_ptr", 32'(bus.ptr), 0);

        // bouncing press, then a long hold
        b_nlm = nlm_cnt; b_nwe = nwe_cnt; b_done = done_cnt;
        bus.sw_addr = 4'h3;
        bus.sw_data = 8'h5A;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) bus.btn_wr = ~bus.btn_wr;
            @(negedge clk);
        end
        chk("bounce_none", 32'(nlm_cnt - b_nlm), 0);
        bus.btn_wr = 1'b1;
        tick(200);
        chk("bounce_done", 32'(done_cnt - b_done), 1);
        chk("bounce_nlm", 32'(nlm_cnt - b_nlm), 1);
        chk("bounce_nwe", 32'(nwe_cnt - b_nwe), 2);
        chk("mem_3", 32'(mem[4'h3]), 'h5A);
        bus.btn_wr = 1'b0;
        wait_idle("bounce_idle");

        // auto-increment from a fresh reset
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ai_ptr0", 32'(bus.ptr), 0);
        bus.auto_inc = 1'b1;
        for (int i = 0; i < 5; i++) press("ai_press", 4'h9, 8'(i + 1));
        chk("mem_0", 32'(mem[4'h0]), 'h01);
        chk("mem_1", 32'(mem[4'h1]), 'h02);
        chk("mem_2", 32'(mem[4'h2]), 'h03);
        chk("mem_4", 32'(mem[4'h4]), 'h05);
        chk("mem_9_untouched", 32'(mem[4'h9]), 32'hxx);
        chk("ai_ptr5", 32'(bus.ptr), 5);
        for (int i = 5; i < 15; i++) press("ai_fill", 4'h9, 8'(8'hE0 + i));
        chk("ai_ptr15", 32'(bus.ptr), 15);
        chk("mem_E", 32'(mem[4'hE]), 'hEE);
        press("ai_wrap", 4'h9, 8'hAB);
        chk("mem_F", 32'(mem[4'hF]), 'hAB);
        chk("ai_ptr_wrap", 32'(bus.ptr), 0);

        // abort during WRITE
        bus.sw_data = 8'h77;
        bus.btn_wr  = 1'b1;
        wait_low("abort_wait_nwe", 1'b1);
        bus.prog = 1'b1;
        b_done = done_cnt;
        @(negedge clk);
        chk("abort_nwe", 32'(bus.nwe), 1);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        tick(5);
        chk("abort_no_done", 32'(done_cnt - b_done), 0);
        chk("abort_ptr", 32'(bus.ptr), 0);
        bus.btn_wr = 1'b0;
        tick(30);

        // press in run mode is discarded
        b_nlm = nlm_cnt; b_nwe = nwe_cnt;
        bus.btn_wr = 1'b1;
        tick(40);
        chk("run_nlm", 32'(nlm_cnt - b_nlm), 0);
        chk("run_nwe", 32'(nwe_cnt - b_nwe), 0);
        chk("run_busy", 32'(bus.busy), 0);
        bus.btn_wr = 1'b0;
        tick(30);
        bus.prog = 1'b0;
        tick(5);
        chk("run_not_queued", 32'(nlm_cnt - b_nlm), 0);

        // switch changes mid-sequence are ignored
        bus.auto_inc = 1'b0;
        bus.sw_addr  = 4'h6;
        bus.sw_data  = 8'h99;
        bus.btn_wr   = 1'b1;
        wait_low("snap_wait_nlm", 1'b0);
        chk("snap_lm_addr", 32'(bus.addr_out), 'h6);
        bus.sw_addr = 4'h1;
        bus.sw_data = 8'h11;
        @(negedge clk);
        chk("snap_setup_addr", 32'(bus.addr_out), 'h6);
        bus.sw_addr = 4'h2;
        bus.sw_data = 8'h22;
        @(negedge clk);
        chk("snap_wr_nwe", 32'(bus.nwe), 0);
        chk("snap_wr_din", 32'(bus.ram_din), 'h99);
        chk("snap_wr_addr", 32'(bus.addr_out), 'h6);
        wait_done("snap_done");
        bus.btn_wr = 1'b0;
        wait_idle("snap_idle");
        chk("mem_6", 32'(mem[4'h6]), 'h99);
        chk("mem_1_kept", 32'(mem[4'h1]), 'h02);
        chk("mem_2_kept", 32'(mem[4'h2]), 'h03);
        chk("snap_ptr", 32'(bus.ptr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
